maria_video_out: RTL

Pixel output stage downstream of the Maria video core. Samples the 8-bit hue/luminance code and sync/blank strobes on each Maria pixel enable, then converts the code to 24-bit RGB through a 512-entry palette memory with one bank each for NTSC and PAL. Delays sync and blank to match the palette latency, forces black during blanking and measures line and frame geometry. Feeds the scaler/video mixer.

---
 rtl/maria_video_out_if.sv | 34 +++
 rtl/maria_video_out.sv | 97 +++++++++
 2 files changed

// File: rtl/maria_video_out_if.sv
// maria_video_out_if: pixel input, palette load and video output bundle of the Maria output stage.
interface maria_video_out_if #(
    parameter int HCNT_W = 10,
    parameter int VCNT_W = 9
);
    logic              ce_pix;
    logic              PAL;
    logic [7:0]        YC;
    logic              hsync_in;
    logic              vsync_in;
    logic              hblank_in;
    logic              vblank_in;
    logic              pal_wr;
    logic [8:0]        pal_addr;
    logic [23:0]       pal_data;
    logic [7:0]        R;
    logic [7:0]        G;
    logic [7:0]        B;
    logic              hsync;
    logic              vsync;
    logic              hblank;
    logic              vblank;
    logic              ce_out;
    logic [HCNT_W-1:0] line_pixels;
    logic [VCNT_W-1:0] frame_lines;
    modport master (
        output ce_pix, PAL, YC, hsync_in, vsync_in, hblank_in, vblank_in, pal_wr, pal_addr, pal_data,
        input  R, G, B, hsync, vsync, hblank, vblank, ce_out, line_pixels, frame_lines
    );
    modport slave (
        input  ce_pix, PAL, YC, hsync_in, vsync_in, hblank_in, vblank_in, pal_wr, pal_addr, pal_data,
        output R, G, B, hsync, vsync, hblank, vblank, ce_out, line_pixels, frame_lines
    );
endinterface

// File: rtl/maria_video_out.sv
// maria_video_out: 3-stage palette lookup of Maria pixels with aligned strobes and line/frame measurement.
// Define MARIA_PALETTE_LOAD_EN for a writable palette RAM; otherwise the palette is a fixed ROM.
module maria_video_out #(
    parameter int HCNT_W = 10,
    parameter int VCNT_W = 9
) (
    input logic           clk_sys,
    input logic           reset,
    maria_video_out_if.slave vo
);
    // Default tables: hue 0 is a grey ramp, other hues mix hue/luma nibbles per bank
    function automatic logic [23:0] pal_rom(input logic [8:0] a);
        logic [3:0] h, l;
        h = a[7:4];
        l = a[3:0];
        return (h == 4'd0) ? {l, l, l, l, l, l} : a[8] ? {h, l, l, h, l, ~h} : {l, h, h, l, ~h, l};
    endfunction
    logic [7:0]        yc_s1_q;
    logic              pal_s1_q;
    logic [3:0]        st_s1_q, st_s2_q, st_o_q; // {hsync, vsync, hblank, vblank}
    logic [23:0]       rd_word, rd_q, rgb_q;
    logic [1:0]        fill_q;
    logic              ce_out_q;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d, line_q, line_d;
    logic [VCNT_W-1:0] vcnt_q, vcnt_d, frame_q, frame_d;
    logic              hs_rise, vs_rise, active;
`ifdef MARIA_PALETTE_LOAD_EN
    typedef logic [23:0] pal_mem_t [512];
    function automatic pal_mem_t pal_init();
        pal_mem_t m;
        for (int i = 0; i < 512; i++) m[i] = pal_rom(9'(i));
        return m;
    endfunction
    logic [23:0] mem_q [512] = pal_init();
    // Write lands at the clock edge, so a same-cycle read sees the old word
    always_ff @(posedge clk_sys) begin
        if (vo.pal_wr) mem_q[vo.pal_addr] <= vo.pal_data;
    end
    assign rd_word = mem_q[{pal_s1_q, yc_s1_q}];
`else
    logic unused_pal;
    assign unused_pal = ^{vo.pal_wr, vo.pal_addr, vo.pal_data};
    assign rd_word = pal_rom({pal_s1_q, yc_s1_q});
`endif
    always_comb begin
        hs_rise = st_s1_q[3] & ~st_s2_q[3];
        vs_rise = st_s1_q[2] & ~st_s2_q[2];
        active  = ~st_s1_q[1] & ~st_s1_q[0];
        hcnt_d  = hs_rise ? '0 : (active && !(&hcnt_q)) ? hcnt_q + 1'b1 : hcnt_q;
        line_d  = (hs_rise && hcnt_q != '0) ? hcnt_q : line_q;
        vcnt_d  = vs_rise ? '0 : (hs_rise && !(&vcnt_q)) ? vcnt_q + 1'b1 : vcnt_q;
        frame_d = vs_rise ? vcnt_q : frame_q;
    end
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            yc_s1_q  <= '0;
            pal_s1_q <= 1'b0;
            st_s1_q  <= '0;
            st_s2_q  <= '0;
            st_o_q   <= '0;
            rd_q     <= '0;
            rgb_q    <= '0;
            fill_q   <= '0;
            ce_out_q <= 1'b0;
            hcnt_q   <= '0;
            line_q   <= '0;
            vcnt_q   <= '0;
            frame_q  <= '0;
        end else begin
            ce_out_q <= vo.ce_pix & fill_q[1];
            if (vo.ce_pix) begin
                fill_q   <= fill_q + {1'b0, ~&fill_q};
                yc_s1_q  <= vo.YC;
                pal_s1_q <= vo.PAL;
                st_s1_q  <= {vo.hsync_in, vo.vsync_in, vo.hblank_in, vo.vblank_in};
                st_s2_q  <= st_s1_q;
                rd_q     <= rd_word;
                rgb_q    <= (st_s2_q[1] | st_s2_q[0]) ? '0 : rd_q;
                st_o_q   <= st_s2_q;
                hcnt_q   <= hcnt_d;
                line_q   <= line_d;
                vcnt_q   <= vcnt_d;
                frame_q  <= frame_d;
            end
        end
    end
    assign vo.R           = rgb_q[23:16];
    assign vo.G           = rgb_q[15:8];
    assign vo.B           = rgb_q[7:0];
    assign vo.hsync       = st_o_q[3];
    assign vo.vsync       = st_o_q[2];
    assign vo.hblank      = st_o_q[1];
    assign vo.vblank      = st_o_q[0];
    assign vo.ce_out      = ce_out_q;
    assign vo.line_pixels = line_q;
    assign vo.frame_lines = frame_q;
endmodule
